// File: rtl/ex.sv
// Execute stage: ALU, NZCV flag register and next-PC selection.
// ALUOut, ALU_res and PCSrc are combinational from the inputs and the stored flags.
// The only state is the 4-bit NZCV register.
module ex #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,     // active-high despite the name
    input  logic [WORD-1:0]      r_data1,
    input  logic [WORD-1:0]      r_data2,
    input  logic [WORD-1:0]      ex_data,
    input  logic [INST_SIZE-1:0] inst,
    input  logic [1:0]           ALUOp,
    input  logic                 ALUSrc,
    input  logic [2:0]           BranchOp,
    input  logic                 SregUp,
    input  logic [WORD-1:0]      pc,
    output logic [WORD-1:0]      ALUOut,
    output logic [1:0]           PCSrc,
    output logic [WORD-1:0]      ALU_res
);

    typedef enum logic [3:0] {
        OpAdd,
        OpSub,
        OpAnd,
        OpOrr,
        OpEor,
        OpLsl,
        OpLsr,
        OpPassB,
        OpOne
    } alu_op_e;

    localparam logic [1:0] PcSeq = 2'd0;
    localparam logic [1:0] PcRel = 2'd1;
    localparam logic [1:0] PcReg = 2'd2;

    logic [WORD-1:0] a_op;
    logic [WORD-1:0] b_op;
    logic [WORD-1:0] b_eff;
    logic [WORD:0]   sum_ext;
    logic [10:0]     opcode;
    logic [5:0]      shamt;
    logic [4:0]      cond;
    alu_op_e         alu_op;
    logic            is_arith;
    logic            is_sub;
    logic            flag_n;
    logic            flag_z;
    logic            flag_c;
    logic            flag_v;
    logic [3:0]      flags_d;
    logic [3:0]      flags_q;
    logic            cond_met;
    logic            unused_inst;

    assign opcode = inst[31:21];
    assign shamt  = inst[15:10];
    assign cond   = inst[4:0];

    // Register-number fields are consumed elsewhere in the pipeline.
    assign unused_inst = ^{inst[20:16], inst[9:5]};

    assign a_op = r_data1;
    assign b_op = ALUSrc ? ex_data : r_data2;

    // Branch target is always computed; PCSrc decides whether it is used.
    assign ALU_res = pc + (ex_data << 2);

    // Decode ALU operation from ALUOp and, for R/I-type, the opcode field.
    always_comb begin
        alu_op = OpAdd;
        unique case (ALUOp)
            2'b00: alu_op = OpAdd;
            2'b01: alu_op = OpPassB;
            2'b11: alu_op = OpOne;
            2'b10: begin
                case (opcode)
                    11'h458, 11'h558: alu_op = OpAdd;
                    11'h658, 11'h758: alu_op = OpSub;
                    11'h450:          alu_op = OpAnd;
                    11'h550:          alu_op = OpOrr;
                    11'h650:          alu_op = OpEor;
                    11'h69B:          alu_op = OpLsl;
                    11'h69A:          alu_op = OpLsr;
                    11'h488, 11'h489: alu_op = OpAdd;
                    11'h688, 11'h689: alu_op = OpSub;
                    default:          alu_op = OpAdd;
                endcase
            end
            default: alu_op = OpAdd;
        endcase
    end

    // Shared adder: subtraction is A + ~B + 1, so carry-out doubles as no-borrow.
    always_comb begin
        is_sub   = (alu_op == OpSub);
        is_arith = (alu_op == OpAdd) || (alu_op == OpSub);
        b_eff    = is_sub ? ~b_op : b_op;
        sum_ext  = {1'b0, a_op} + {1'b0, b_eff} + {{WORD{1'b0}}, is_sub};
    end

    // Result mux.
    always_comb begin
        ALUOut = sum_ext[WORD-1:0];
        unique case (alu_op)
            OpAdd, OpSub: ALUOut = sum_ext[WORD-1:0];
            OpAnd:        ALUOut = a_op & b_op;
            OpOrr:        ALUOut = a_op | b_op;
            OpEor:        ALUOut = a_op ^ b_op;
            OpLsl:        ALUOut = a_op << shamt;
            OpLsr:        ALUOut = a_op >> shamt;
            OpPassB:      ALUOut = b_op;
            OpOne:        ALUOut = {{(WORD-1){1'b0}}, 1'b1};
            default:      ALUOut = sum_ext[WORD-1:0];
        endcase
    end

    // Combinational NZCV; C and V only meaningful for add/sub.
    always_comb begin
        flag_n  = ALUOut[WORD-1];
        flag_z  = (ALUOut == '0);
        flag_c  = is_arith & sum_ext[WORD];
        flag_v  = is_arith & (a_op[WORD-1] == b_eff[WORD-1])
                           & (sum_ext[WORD-1] != a_op[WORD-1]);
        flags_d = {flag_n, flag_z, flag_c, flag_v};
    end

    // Flag register: cleared asynchronously, loaded only when SregUp is set.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            flags_q <= 4'b0000;
        end else if (SregUp) begin
            flags_q <= flags_d;
        end
    end

    // Evaluate B.cond condition against the stored flags.
    always_comb begin
        logic n_q, z_q, c_q, v_q;
        {n_q, z_q, c_q, v_q} = flags_q;
        cond_met = 1'b0;
        case (cond)
            5'd0:    cond_met = z_q;
            5'd1:    cond_met = !z_q;
            5'd2:    cond_met = c_q;
            5'd3:    cond_met = !c_q;
            5'd4:    cond_met = n_q;
            5'd5:    cond_met = !n_q;
            5'd6:    cond_met = v_q;
            5'd7:    cond_met = !v_q;
            5'd8:    cond_met = c_q & !z_q;
            5'd9:    cond_met = !(c_q & !z_q);
            5'd10:   cond_met = (n_q == v_q);
            5'd11:   cond_met = (n_q != v_q);
            5'd12:   cond_met = !z_q & (n_q == v_q);
            5'd13:   cond_met = !(!z_q & (n_q == v_q));
            5'd14:   cond_met = 1'b1;
            5'd15:   cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // Next-PC select; CBZ/CBNZ look at the live Z, B.cond at the stored flags.
    always_comb begin
        PCSrc = PcSeq;
        case (BranchOp)
            3'b001:  PCSrc = flag_z ? PcRel : PcSeq;
            3'b010:  PCSrc = flag_z ? PcSeq : PcRel;
            3'b011:  PCSrc = PcRel;
            3'b100:  PCSrc = cond_met ? PcRel : PcSeq;
            3'b101:  PCSrc = PcReg;
            default: PCSrc = PcSeq;
        endcase
    end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage.
module tb_ex;

    logic        tb_clk;
    logic        rst_n;
    logic [63:0] r_data1;
    logic [63:0] r_data2;
    logic [63:0] ex_data;
    logic [31:0] inst;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic [2:0]  BranchOp;
    logic        SregUp;
    logic [63:0] pc;
    logic [63:0] ALUOut;
    logic [1:0]  PCSrc;
    logic [63:0] ALU_res;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex #(.WORD(64), .INST_SIZE(32)) dut (
        .clk      (tb_clk),
        .rst_n    (rst_n),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .ex_data  (ex_data),
        .inst     (inst),
        .ALUOp    (ALUOp),
        .ALUSrc   (ALUSrc),
        .BranchOp (BranchOp),
        .SregUp   (SregUp),
        .pc       (pc),
        .ALUOut   (ALUOut),
        .PCSrc    (PCSrc),
        .ALU_res  (ALU_res)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    localparam logic [31:0] I_ADD  = 32'h8B000000;
    localparam logic [31:0] I_ADDS = 32'hAB000000;
    localparam logic [31:0] I_SUBS = 32'hEB000000;
    localparam logic [31:0] I_AND  = 32'h8A000000;
    localparam logic [31:0] I_ORR  = 32'hAA000000;
    localparam logic [31:0] I_EOR  = 32'hCA000000;
    localparam logic [31:0] I_LSL4 = 32'hD3601000;
    localparam logic [31:0] I_LSR4 = 32'hD3401000;
    localparam logic [31:0] I_SUBI = 32'hD1000000;
    localparam logic [31:0] I_BCND = 32'h54000000;

    task automatic drive(input logic [63:0] a, input logic [63:0] b2, input logic [63:0] ex,
                         input logic [31:0] ins, input logic [1:0] aop, input logic asrc,
                         input logic [2:0] brop, input logic sreg, input logic [63:0] pcv);
        r_data1 = a; r_data2 = b2; ex_data = ex; inst = ins; ALUOp = aop;
        ALUSrc = asrc; BranchOp = brop; SregUp = sreg; pc = pcv;
        #1;
    endtask

    // Drive a B.cond with the given condition code and check PCSrc.
    task automatic check_cond(input string name, input logic [4:0] cc, input logic [1:0] want);
        drive(64'd0, 64'd0, 64'd0, I_BCND | {27'd0, cc}, 2'b01, 1'b0, 3'b100, 1'b0, 64'd0);
        total_cnt++;
        if (PCSrc !== want) $display("FAIL %s: PCSrc got %0d want %0d", name, PCSrc, want);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        // SUBS 5-5 with SregUp during reset must not load Z.
        drive(64'd5, 64'd5, 64'd0, I_SUBS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        repeat (2) @(posedge tb_clk);
        #1;
        check_cond("reset_eq_in_reset", 5'd0, 2'd0);
        check_cond("reset_al_in_reset", 5'd14, 2'd1);
        // Combinational path works during reset.
        drive(64'd22, 64'd4, 64'd64, 32'd0, 2'b00, 1'b1, 3'b000, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd86) $display("FAIL reset_alu: ALUOut got %0d want 86", ALUOut);
        else pass_cnt++;
        rst_n = 1'b0;
        @(posedge tb_clk);
        #1;
        check_cond("reset_eq_after", 5'd0, 2'd0);
        check_cond("reset_nv_after", 5'd16, 2'd0);
    endtask

    task automatic test_ldur;
        drive(64'd22, 64'd4, 64'd64, 32'd0, 2'b00, 1'b1, 3'b000, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd86) $display("FAIL ldur_aluout: got %0d want 86", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd0) $display("FAIL ldur_pcsrc: got %0d want 0", PCSrc);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'd456) $display("FAIL ldur_alures: got %0d want 456", ALU_res);
        else pass_cnt++;
    endtask

    task automatic test_add_sub;
        drive(64'd19, 64'd9, 64'h8B09026A, 32'h8B09026A, 2'b10, 1'b0, 3'b000, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd28) $display("FAIL add_aluout: got %0d want 28", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'h22C240A70)
            $display("FAIL add_alures: got %0h want 22c240a70", ALU_res);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd0) $display("FAIL add_pcsrc: got %0d want 0", PCSrc);
        else pass_cnt++;
        drive(64'd20, 64'd20, 64'hCB0A028B, 32'hCB0A028B, 2'b10, 1'b0, 3'b000, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd0) $display("FAIL sub_aluout: got %0d want 0", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'h32C280AF4)
            $display("FAIL sub_alures: got %0h want 32c280af4", ALU_res);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd0) $display("FAIL sub_pcsrc: got %0d want 0", PCSrc);
        else pass_cnt++;
    endtask

    task automatic test_logic_shift;
        logic [31:0] ops  [6];
        logic [63:0] want [6];
        ops  = '{I_AND, I_ORR, I_EOR, I_LSL4, I_LSR4, 32'd0};
        want = '{64'hF000, 64'hFFF0, 64'h0FF0, 64'hF0F00, 64'hF0F, 64'h1EFF0};
        for (int i = 0; i < 6; i++) begin
            drive(64'hF0F0, 64'hFF00, 64'd0, ops[i], 2'b10, 1'b0, 3'b000, 1'b0, 64'd0);
            total_cnt++;
            if (ALUOut !== want[i])
                $display("FAIL logic_op%0d: got %0h want %0h", i, ALUOut, want[i]);
            else pass_cnt++;
        end
        drive(64'hF0F0, 64'hFF00, 64'h10, I_SUBI, 2'b10, 1'b1, 3'b000, 1'b0, 64'd0);
        total_cnt++;
        if (ALUOut !== 64'hF0E0) $display("FAIL subi: got %0h want f0e0", ALUOut);
        else pass_cnt++;
        // Wrap-around modulo 2^64.
        drive(64'd0, 64'd1, 64'd0, I_SUBS, 2'b10, 1'b0, 3'b000, 1'b0, 64'd0);
        total_cnt++;
        if (ALUOut !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL sub_wrap: got %0h want ffffffffffffffff", ALUOut);
        else pass_cnt++;
    endtask

    task automatic test_branches;
        drive(64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 2'b01, 1'b1, 3'b001, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'hFFFF_FFFF_FFFF_FFFB)
            $display("FAIL cbz_aluout: got %0h want fffffffffffffffb", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd0) $display("FAIL cbz_pcsrc: got %0d want 0", PCSrc);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'd180) $display("FAIL cbz_alures: got %0d want 180", ALU_res);
        else pass_cnt++;
        drive(64'd0, 64'd0, 64'd0, 32'd0, 2'b01, 1'b1, 3'b001, 1'b0, 64'd200);
        total_cnt++;
        if (PCSrc !== 2'd1) $display("FAIL cbz_taken: got %0d want 1", PCSrc);
        else pass_cnt++;
        drive(64'd0, 64'd0, 64'd8, 32'd0, 2'b01, 1'b1, 3'b010, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd8) $display("FAIL cbnz_aluout: got %0d want 8", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd1) $display("FAIL cbnz_pcsrc: got %0d want 1", PCSrc);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'hE8) $display("FAIL cbnz_alures: got %0h want e8", ALU_res);
        else pass_cnt++;
        drive(64'd2, 64'd0, 64'd64, 32'd0, 2'b11, 1'b0, 3'b011, 1'b0, 64'd200);
        total_cnt++;
        if (ALUOut !== 64'd1) $display("FAIL b_aluout: got %0d want 1", ALUOut);
        else pass_cnt++;
        total_cnt++;
        if (PCSrc !== 2'd1) $display("FAIL b_pcsrc: got %0d want 1", PCSrc);
        else pass_cnt++;
        total_cnt++;
        if (ALU_res !== 64'd456) $display("FAIL b_alures: got %0d want 456", ALU_res);
        else pass_cnt++;
        drive(64'h1000, 64'd0, 64'd0, 32'd0, 2'b00, 1'b0, 3'b101, 1'b0, 64'd200);
        total_cnt++;
        if (PCSrc !== 2'd2) $display("FAIL br_pcsrc: got %0d want 2", PCSrc);
        else pass_cnt++;
        drive(64'd0, 64'd0, 64'd0, 32'd0, 2'b11, 1'b0, 3'b111, 1'b0, 64'd200);
        total_cnt++;
        if (PCSrc !== 2'd0) $display("FAIL rsvd_pcsrc: got %0d want 0", PCSrc);
        else pass_cnt++;
    endtask

    task automatic test_flags_cond;
        // SUBS 5-5: N0 Z1 C1 V0.
        drive(64'd5, 64'd5, 64'd0, I_SUBS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("eq_after_subs", 5'd0, 2'd1);
        check_cond("hs_after_subs", 5'd2, 2'd1);
        check_cond("hi_after_subs", 5'd8, 2'd0);
        check_cond("gt_after_subs", 5'd12, 2'd0);
        check_cond("le_after_subs", 5'd13, 2'd1);
        // Flags hold while SregUp is low.
        drive(64'd5, 64'd7, 64'd0, I_ADD, 2'b10, 1'b0, 3'b000, 1'b0, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("eq_hold", 5'd0, 2'd1);
        // CBNZ uses live Z, not the stored Z=1.
        drive(64'd0, 64'd0, 64'd8, 32'd0, 2'b01, 1'b1, 3'b010, 1'b0, 64'd0);
        total_cnt++;
        if (PCSrc !== 2'd1) $display("FAIL cbnz_live_z: got %0d want 1", PCSrc);
        else pass_cnt++;
        // ADDS 0x7fff..f + 1: N1 Z0 C0 V1.
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, I_ADDS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("vs_after_ovf", 5'd6, 2'd1);
        check_cond("mi_after_ovf", 5'd4, 2'd1);
        check_cond("lt_after_ovf", 5'd11, 2'd0);
        check_cond("hs_after_ovf", 5'd2, 2'd0);
        check_cond("ne_after_ovf", 5'd1, 2'd1);
        // ADDS 0xffff..f + 1: N0 Z1 C1 V0.
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, I_ADDS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("hs_after_carry", 5'd2, 2'd1);
        check_cond("vc_after_carry", 5'd7, 2'd1);
        // SUBS 3-5: N1 Z0 C0 V0.
        drive(64'd3, 64'd5, 64'd0, I_SUBS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("lo_after_borrow", 5'd3, 2'd1);
        check_cond("lt_after_borrow", 5'd11, 2'd1);
        check_cond("ge_after_borrow", 5'd10, 2'd0);
        check_cond("nv_code31", 5'd31, 2'd0);
        check_cond("al_code15", 5'd15, 2'd1);
        // Reset pulse clears flags: SUBS 5-5 then EQ, then reset, then EQ again.
        drive(64'd5, 64'd5, 64'd0, I_SUBS, 2'b10, 1'b0, 3'b000, 1'b1, 64'd0);
        @(posedge tb_clk);
        #1;
        check_cond("eq_before_rst", 5'd0, 2'd1);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        check_cond("eq_after_rst", 5'd0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(64'd0, 64'd0, 64'd0, 32'd0, 2'b00, 1'b0, 3'b000, 1'b0, 64'd0);
        test_reset;
        test_ldur;
        test_add_sub;
        test_logic_shift;
        test_branches;
        test_flags_cond;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
